// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode/operand-fetch stage with busy scoreboard and ID/EX register; optional same-cycle writeback bypass under OPERAND_BYPASS_EN
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid_i,
  output logic                  inst_ready_o,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [4:0]            rs1_addr_o,
  output logic [4:0]            rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic                  wb_valid_i,
  input  logic [4:0]            wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [31:0]           ex_inst_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [4:0]            ex_rd_addr_o,
  output logic                  ex_rd_we_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  rd_we;
  logic                  use_rs1;
  logic                  use_rs2;
  logic                  hazard;
  logic                  accept;
  logic [REG_COUNT-1:0]  busy;
  logic [REG_COUNT-1:0]  busy_nxt;
  logic [REG_COUNT-1:0]  busy_chk;
  logic [REG_COUNT-1:0]  wb_clear_mask;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;

  assign opcode     = inst_i[6:0];
  assign rd         = inst_i[11:7];
  assign rs1        = inst_i[19:15];
  assign rs2        = inst_i[24:20];
  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  // Opcode decode: which instructions write rd and which read rs1/rs2
  always_comb begin
    rd_we   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: rd_we = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        rd_we   = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_OP: begin
        rd_we   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    // x0 is never a real destination, so it never enters the scoreboard
    if (rd == 5'd0) rd_we = 1'b0;
  end

  // One-hot of the register retiring this cycle; writes to x0 are ignored
  always_comb begin
    wb_clear_mask = '0;
    if (wb_valid_i && (wb_rd_addr_i != 5'd0)) wb_clear_mask[wb_rd_addr_i] = 1'b1;
  end

`ifdef OPERAND_BYPASS_EN
  // A register retiring this cycle is already available through the bypass mux
  assign busy_chk = busy & ~wb_clear_mask;

  // Operand select: x0 reads zero, a matching writeback overrides the regfile
  always_comb begin
    op1 = rs1_data_i;
    op2 = rs2_data_i;
    if (wb_valid_i && (wb_rd_addr_i == rs1)) op1 = wb_data_i;
    if (wb_valid_i && (wb_rd_addr_i == rs2)) op2 = wb_data_i;
    if (rs1 == 5'd0) op1 = '0;
    if (rs2 == 5'd0) op2 = '0;
  end
`else
  logic unused_wb_data;

  // A register retiring this cycle stays busy until the regfile holds the new value
  assign busy_chk       = busy;
  assign unused_wb_data = ^wb_data_i;

  // Operand select: x0 reads zero regardless of what the regfile returns
  always_comb begin
    op1 = (rs1 == 5'd0) ? '0 : rs1_data_i;
    op2 = (rs2 == 5'd0) ? '0 : rs2_data_i;
  end
`endif

  assign hazard = (use_rs1 & busy_chk[rs1]) | (use_rs2 & busy_chk[rs2]) | (rd_we & busy_chk[rd]);
  assign inst_ready_o = !rst && !flush_i && !hazard && (!ex_valid_o || ex_ready_i);
  assign accept = inst_valid_i && inst_ready_o;

  // Scoreboard update: retire, drop the killed writer on flush, then mark the new writer
  always_comb begin
    busy_nxt = busy & ~wb_clear_mask;
    if (flush_i && ex_valid_o && ex_rd_we_o) busy_nxt[ex_rd_addr_o] = 1'b0;
    if (accept && rd_we) busy_nxt[rd] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // ID/EX pipeline register: flush kills, accept loads, consume without refill empties
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_inst_o     <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_rd_we_o    <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= pc_i;
      ex_inst_o     <= inst_i;
      ex_rs1_data_o <= op1;
      ex_rs2_data_o <= op2;
      ex_rd_addr_o  <= rd;
      ex_rd_we_o    <= rd_we;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage (default build, no bypass)
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_inst_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_we_o;

  int total = 0;
  int bad   = 0;

  operand_fetch_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_inst_o(ex_inst_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o)
  );

  always #5 clk = ~clk;

  // Environment regfile: x0 deliberately returns junk so the stage must zero it
  logic [31:0] regs [32];
  assign rs1_data_i = regs[rs1_addr_o];
  assign rs2_data_i = regs[rs2_addr_o];

  always @(posedge clk) begin
    if (rst) begin
      regs[0] <= 32'hdeadbeef;
      for (int i = 1; i < 32; i++) regs[i] <= 32'h100 * i + 32'h11;
    end else if (wb_valid_i && wb_rd_addr_i != 5'd0) begin
      regs[wb_rd_addr_i] <= wb_data_i;
    end
  end

  // Reference model: ID/EX contents plus the queue of writers already past EX
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbe_t;

  wbe_t        wbq[$];
  logic        m_v;
  logic [31:0] m_pc, m_inst, m_op1, m_op2;
  logic [4:0]  m_rd;
  logic        m_we;

  function automatic void decode(input logic [31:0] i, output logic we, output logic u1, output logic u2);
    logic [6:0] o;
    o  = i[6:0];
    we = (o == 7'b0110111) || (o == 7'b0010111) || (o == 7'b1101111) || (o == 7'b1100111) ||
         (o == 7'b0000011) || (o == 7'b0010011) || (o == 7'b0110011);
    if (i[11:7] == 5'd0) we = 1'b0;
    u1 = (o == 7'b1100111) || (o == 7'b1100011) || (o == 7'b0000011) || (o == 7'b0100011) ||
         (o == 7'b0010011) || (o == 7'b0110011);
    u2 = (o == 7'b1100011) || (o == 7'b0100011) || (o == 7'b0110011);
  endfunction

  // A register is pending while any not-yet-retired instruction will write it
  function automatic logic pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_v && m_we && m_rd == r) return 1'b1;
    foreach (wbq[k]) if (wbq[k].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid_i = 1'b0; inst_i = '0; pc_i = '0; ex_ready_i = 1'b0; flush_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_addr_i = '0; wb_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    total++;
    if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", inst_ready_o); end
    tick();
    tick();
    total++;
    if ({ex_valid_o, ex_rd_we_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o} !== '0) begin
      bad++; $display("FAIL reset_ex got valid=%b we=%b pc=%h inst=%h want all zero", ex_valid_o, ex_rd_we_o, ex_pc_o, ex_inst_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_issue();
    inst_valid_i = 1'b1; inst_i = 32'h00500093; pc_i = 32'h100; ex_ready_i = 1'b0;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", inst_ready_o); end
    tick();
    inst_valid_i = 1'b0;
    total++;
    if ({ex_valid_o, ex_rd_addr_o, ex_rd_we_o, ex_pc_o, ex_rs1_data_o} !== {1'b1, 5'd1, 1'b1, 32'h100, 32'h0}) begin
      bad++; $display("FAIL issue_idex got v=%b rd=%0d we=%b pc=%h op1=%h want v=1 rd=1 we=1 pc=100 op1=0",
                      ex_valid_o, ex_rd_addr_o, ex_rd_we_o, ex_pc_o, ex_rs1_data_o);
    end
  endtask

  task automatic test_raw();
    ex_ready_i = 1'b1; inst_valid_i = 1'b1; inst_i = 32'h00108133; pc_i = 32'h104;
    #1;
    total++;
    if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b want=0", inst_ready_o); end
    tick();
    tick();
    total++;
    if ({ex_valid_o, inst_ready_o} !== 2'b00) begin
      bad++; $display("FAIL raw_wait got v=%b rdy=%b want v=0 rdy=0", ex_valid_o, inst_ready_o);
    end
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd1; wb_data_i = 32'd5;
    #1;
    total++;
    if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL raw_wb_cycle got=%b want=0", inst_ready_o); end
    tick();
    wb_valid_i = 1'b0;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL raw_after_wb got=%b want=1", inst_ready_o); end
    ex_ready_i = 1'b0;
    tick();
    inst_valid_i = 1'b0;
    total++;
    if ({ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o} !== {1'b1, 32'd5, 32'd5, 5'd2}) begin
      bad++; $display("FAIL raw_operands got v=%b op1=%h op2=%h rd=%0d want v=1 op1=5 op2=5 rd=2",
                      ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    inst_valid_i = 1'b1; inst_i = 32'h12345037; pc_i = 32'h108; ex_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", c, inst_ready_o); end
      tick();
      total++;
      if ({ex_valid_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o} !==
          {1'b1, 32'h104, 32'h00108133, 32'd5, 32'd5, 5'd2, 1'b1}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got v=%b pc=%h inst=%h want v=1 pc=104 inst=00108133",
                        c, ex_valid_o, ex_pc_o, ex_inst_o);
      end
    end
    ex_ready_i = 1'b1;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", inst_ready_o); end
    tick();
    total++;
    if ({ex_valid_o, ex_inst_o, ex_rd_we_o, ex_pc_o} !== {1'b1, 32'h12345037, 1'b0, 32'h108}) begin
      bad++; $display("FAIL b2b_idex got v=%b inst=%h we=%b pc=%h want v=1 inst=12345037 we=0 pc=108",
                      ex_valid_o, ex_inst_o, ex_rd_we_o, ex_pc_o);
    end
    inst_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd2; wb_data_i = 32'd7;
    tick();
    wb_valid_i = 1'b0;
    total++;
    if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", ex_valid_o); end
  endtask

  task automatic test_store();
    inst_valid_i = 1'b1; inst_i = 32'h00112223; pc_i = 32'h10c; ex_ready_i = 1'b0;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL store_ready got=%b want=1", inst_ready_o); end
    tick();
    total++;
    if ({ex_valid_o, ex_rd_we_o, ex_rs1_data_o, ex_rs2_data_o} !== {1'b1, 1'b0, 32'd7, 32'd5}) begin
      bad++; $display("FAIL store_idex got v=%b we=%b op1=%h op2=%h want v=1 we=0 op1=7 op2=5",
                      ex_valid_o, ex_rd_we_o, ex_rs1_data_o, ex_rs2_data_o);
    end
    inst_i = 32'h000202b3; pc_i = 32'h110; ex_ready_i = 1'b1;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL store_no_busy got=%b want=1", inst_ready_o); end
    inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    inst_valid_i = 1'b1; inst_i = 32'h00100193; pc_i = 32'h200; ex_ready_i = 1'b0;
    tick();
    inst_i = 32'h12345037; flush_i = 1'b1;
    #1;
    total++;
    if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", inst_ready_o); end
    tick();
    flush_i = 1'b0;
    total++;
    if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b want=0", ex_valid_o); end
    inst_i = 32'h00018213; pc_i = 32'h204;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL flush_busy_clear got=%b want=1", inst_ready_o); end
    tick();
    inst_valid_i = 1'b0;
    total++;
    if ({ex_valid_o, ex_rd_addr_o, ex_rs1_data_o} !== {1'b1, 5'd4, 32'h311}) begin
      bad++; $display("FAIL flush_next got v=%b rd=%0d op1=%h want v=1 rd=4 op1=311", ex_valid_o, ex_rd_addr_o, ex_rs1_data_o);
    end
  endtask

  task automatic test_reset_mid();
    ex_ready_i = 1'b1; inst_valid_i = 1'b1; inst_i = 32'h00500093; pc_i = 32'h300;
    tick();
    inst_valid_i = 1'b0; ex_ready_i = 1'b0;
    total++;
    if ({ex_valid_o, ex_rd_addr_o} !== {1'b1, 5'd1}) begin
      bad++; $display("FAIL rstmid_pre got v=%b rd=%0d want v=1 rd=1", ex_valid_o, ex_rd_addr_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", inst_ready_o); end
    tick();
    rst = 1'b0;
    total++;
    if ({ex_valid_o, ex_rd_we_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o} !== '0) begin
      bad++; $display("FAIL rstmid_ex got v=%b we=%b pc=%h inst=%h want all zero", ex_valid_o, ex_rd_we_o, ex_pc_o, ex_inst_o);
    end
    inst_valid_i = 1'b1; inst_i = 32'h00108133; pc_i = 32'h304;
    #1;
    total++;
    if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", inst_ready_o); end
    idle();
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] r;
    logic        do_wb, exp_ready, acc, we, u1, u2, haz;
    wbe_t        e;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b0110011, 7'b1100011, 7'b0100011, 7'b1110011, 7'b1111111};
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    m_v = 1'b0;
    wbq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r        = $urandom;
      r[6:0]   = ops[$urandom_range(0, 10)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      inst_i       = r;
      pc_i         = $urandom;
      inst_valid_i = ($urandom_range(0, 3) != 0);
      ex_ready_i   = ($urandom_range(0, 2) != 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      do_wb        = 1'b0;
      if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
        do_wb = 1'b1;
        wb_valid_i = 1'b1; wb_rd_addr_i = wbq[0].rd; wb_data_i = wbq[0].data;
      end else if ($urandom_range(0, 15) == 0) begin
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd0; wb_data_i = $urandom;
      end else begin
        wb_valid_i = 1'b0; wb_rd_addr_i = 5'($urandom_range(0, 31)); wb_data_i = $urandom;
      end
      #1;
      decode(r, we, u1, u2);
      haz = (u1 && pending(r[19:15])) || (u2 && pending(r[24:20])) || (we && pending(r[11:7]));
      exp_ready = !flush_i && !haz && (!m_v || ex_ready_i);
      total++;
      if (inst_ready_o !== exp_ready) begin
        bad++; $display("FAIL rand_ready cyc=%0d inst=%h got=%b want=%b", cyc, r, inst_ready_o, exp_ready);
      end
      acc = inst_valid_i && exp_ready;
      if (do_wb) void'(wbq.pop_front());
      if (flush_i) begin
        m_v = 1'b0;
      end else begin
        if (m_v && ex_ready_i) begin
          if (m_we) begin
            e.rd = m_rd; e.data = $urandom;
            wbq.push_back(e);
          end
          m_v = 1'b0;
        end
        if (acc) begin
          m_v = 1'b1; m_pc = pc_i; m_inst = r; m_rd = r[11:7]; m_we = we;
          m_op1 = (r[19:15] == 5'd0) ? 32'd0 : regs[r[19:15]];
          m_op2 = (r[24:20] == 5'd0) ? 32'd0 : regs[r[24:20]];
        end
      end
      tick();
      total++;
      if (ex_valid_o !== m_v) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, ex_valid_o, m_v);
      end
      if (m_v) begin
        total++;
        if ({ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o} !==
            {m_pc, m_inst, m_op1, m_op2, m_rd, m_we}) begin
          bad++; $display("FAIL rand_idex cyc=%0d got pc=%h inst=%h op1=%h op2=%h rd=%0d we=%b want pc=%h inst=%h op1=%h op2=%h rd=%0d we=%b",
                          cyc, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o,
                          m_pc, m_inst, m_op1, m_op2, m_rd, m_we);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw();
    test_back_to_back();
    test_store();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
